cache_controller: RTL and testbench

Sequencing FSM between the CPU load/store port, the direct-mapped write-back cache array (2048 one-word lines, 19-bit tag, 11-bit index) and main memory. It accepts one word access at a time, pulses the cache array's edge-triggered enable, resolves misses with a memory read and refill, and writes back dirty evicted lines. It stalls the pipeline while busy and keeps hit/miss statistics.

---
 rtl/cache_controller.sv | 266 ++++++++++++++++++++++++++
 tb/tb_cache_controller.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_controller.sv
// ============================================================================
// cache_controller
// ----------------------------------------------------------------------------
// Purpose:
//   Sequencing FSM sitting between the CPU load/store port, a direct-mapped
//   write-back cache array (2048 one-word lines, 19-bit tag, 11-bit index)
//   and main memory. One word access is handled at a time:
//     - the request is latched and presented to the cache array with a
//       single-cycle enable pulse,
//     - a load miss triggers a memory read followed by a refill of the line,
//     - any dirty line pushed out of the array (by a store or by a refill)
//       is written back to memory before the CPU is released,
//     - the CPU is told to stall for as long as the FSM is not idle, and a
//       one-cycle cpu_ready pulse marks completion.
//   Load hits and load misses are counted; stores are not counted.
//
// Ports:
//   clk, rst            clock (rising edge) and synchronous active-high reset
//   cpu_req/we/addr/wdata  CPU request, sampled only while idle
//   cpu_rdata, cpu_ready   load data and one-cycle completion pulse
//   stall                  high whenever the FSM is not idle
//   cache_en/we/from_mem   cache operation pulse and its qualifiers
//   cache_addr/wdata       latched request address and write data
//   cache_rdata/hit/evicted/ready/evicted_tag  cache array status
//   mem_req/we/addr/wdata  memory request, held until mem_ack
//   mem_rdata, mem_ack     memory read data and one-cycle completion
//   hit_count, miss_count  wrapping 32-bit load statistics
//
// All outputs are decoded from registered state and data only; no input
// reaches an output through combinational logic.
// ============================================================================
module cache_controller #(
    parameter int TAG_W   = 19,
    parameter int INDEX_W = 11
) (
    input  logic              clk,
    input  logic              rst,

    // CPU side
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_ready,
    output logic              stall,

    // Cache array side
    output logic              cache_en,
    output logic              cache_we,
    output logic              cache_from_mem,
    output logic [31:0]       cache_addr,
    output logic [31:0]       cache_wdata,
    input  logic [31:0]       cache_rdata,
    input  logic              cache_hit,
    input  logic              cache_evicted,
    input  logic              cache_ready,
    input  logic [TAG_W-1:0]  cache_evicted_tag,

    // Main memory side
    output logic              mem_req,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,

    // Statistics
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        CHECK,
        MEM_RD,
        FILL,
        FILL_CHK,
        WB,
        RESP
    } state_t;

    state_t             state_q,      state_d;

    // Latched request
    logic [31:0]        reqAddr_q,    reqAddr_d;
    logic               reqWe_q,      reqWe_d;
    logic [31:0]        reqWdata_q,   reqWdata_d;

    // Word returned to the CPU on a load; on a miss it is also the refill word
    logic [31:0]        readData_q,   readData_d;

    // Dirty line pushed out of the array, waiting to be written back
    logic [31:0]        victimData_q, victimData_d;
    logic [TAG_W-1:0]   victimTag_q,  victimTag_d;

    // Load statistics
    logic [31:0]        hitCount_q,   hitCount_d;
    logic [31:0]        missCount_q,  missCount_d;

    // ------------------------------------------------------------------------
    // State and data registers. Reset returns the FSM to IDLE and clears every
    // register, which drops any access in flight without completing it. The
    // cache array itself is not touched by this reset.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            reqAddr_q    <= '0;
            reqWe_q      <= 1'b0;
            reqWdata_q   <= '0;
            readData_q   <= '0;
            victimData_q <= '0;
            victimTag_q  <= '0;
            hitCount_q   <= '0;
            missCount_q  <= '0;
        end else begin
            state_q      <= state_d;
            reqAddr_q    <= reqAddr_d;
            reqWe_q      <= reqWe_d;
            reqWdata_q   <= reqWdata_d;
            readData_q   <= readData_d;
            victimData_q <= victimData_d;
            victimTag_q  <= victimTag_d;
            hitCount_q   <= hitCount_d;
            missCount_q  <= missCount_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state, data capture and output decode. Every output is a function
    // of state_q and registered data only, so cache_en is high for exactly one
    // cycle in LOOKUP and one in FILL, and those states are never adjacent.
    // The memory request is held for the whole MEM_RD / WB state, so address,
    // direction and data stay stable until the ack is taken, and it drops in
    // the cycle after the ack because the state has moved on.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        reqAddr_d      = reqAddr_q;
        reqWe_d        = reqWe_q;
        reqWdata_d     = reqWdata_q;
        readData_d     = readData_q;
        victimData_d   = victimData_q;
        victimTag_d    = victimTag_q;
        hitCount_d     = hitCount_q;
        missCount_d    = missCount_q;

        cpu_ready      = 1'b0;
        cpu_rdata      = '0;
        stall          = (state_q != IDLE);
        cache_en       = 1'b0;
        cache_we       = 1'b0;
        cache_from_mem = 1'b0;
        cache_wdata    = '0;
        mem_req        = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;

        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    reqAddr_d  = cpu_addr;
                    reqWe_d    = cpu_we;
                    reqWdata_d = cpu_wdata;
                    // Cleared so a store completes with zero on cpu_rdata
                    readData_d = '0;
                    state_d    = LOOKUP;
                end
            end

            LOOKUP: begin
                cache_en    = 1'b1;
                cache_we    = reqWe_q;
                cache_wdata = reqWdata_q;
                state_d     = CHECK;
            end

            CHECK: begin
                if (cache_ready) begin
                    if (!reqWe_q) begin
                        if (cache_hit) begin
                            readData_d = cache_rdata;
                            hitCount_d = hitCount_q + 32'd1;
                            state_d    = RESP;
                        end else begin
                            missCount_d = missCount_q + 32'd1;
                            state_d     = MEM_RD;
                        end
                    end else if (cache_evicted) begin
                        // The store displaced a dirty line of another tag
                        victimData_d = cache_rdata;
                        victimTag_d  = cache_evicted_tag;
                        state_d      = WB;
                    end else begin
                        state_d = RESP;
                    end
                end
            end

            MEM_RD: begin
                mem_req  = 1'b1;
                mem_addr = {reqAddr_q[31:2], 2'b00};
                if (mem_ack) begin
                    readData_d = mem_rdata;
                    state_d    = FILL;
                end
            end

            FILL: begin
                cache_en       = 1'b1;
                cache_we       = 1'b1;
                cache_from_mem = 1'b1;
                cache_wdata    = readData_q;
                state_d        = FILL_CHK;
            end

            FILL_CHK: begin
                if (cache_ready) begin
                    if (cache_evicted) begin
                        // The refill displaced a dirty line of another tag
                        victimData_d = cache_rdata;
                        victimTag_d  = cache_evicted_tag;
                        state_d      = WB;
                    end else begin
                        state_d = RESP;
                    end
                end
            end

            WB: begin
                // Victim shares the request's index; only the tag differs
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {victimTag_q, reqAddr_q[INDEX_W+1:2], 2'b00};
                mem_wdata = victimData_q;
                if (mem_ack) begin
                    state_d = RESP;
                end
            end

            RESP: begin
                cpu_ready = 1'b1;
                cpu_rdata = readData_q;
                state_d   = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registered values exposed directly
    // ------------------------------------------------------------------------
    assign cache_addr = reqAddr_q;
    assign hit_count  = hitCount_q;
    assign miss_count = missCount_q;

endmodule

// File: tb/tb_cache_controller.sv
// ============================================================================
// tb_cache_controller
// ----------------------------------------------------------------------------
// Self-checking bench for cache_controller. The environment contains a
// behavioural direct-mapped write-back cache array and a main memory with a
// programmable number of wait cycles. Expected results come from a flat
// word-addressed memory image plus a per-line residency table, and latencies
// from the documented cycle counts of each access kind.
// ============================================================================
module tb_cache_controller;

    localparam int TAG_W   = 19;
    localparam int INDEX_W = 11;
    localparam int LINES   = 2048;

    logic              clk = 1'b0;
    logic              rst = 1'b1;

    logic              cpu_req   = 1'b0;
    logic              cpu_we    = 1'b0;
    logic [31:0]       cpu_addr  = '0;
    logic [31:0]       cpu_wdata = '0;
    logic [31:0]       cpu_rdata;
    logic              cpu_ready;
    logic              stall;

    logic              cache_en;
    logic              cache_we;
    logic              cache_from_mem;
    logic [31:0]       cache_addr;
    logic [31:0]       cache_wdata;
    logic [31:0]       cache_rdata       = '0;
    logic              cache_hit         = 1'b0;
    logic              cache_evicted     = 1'b0;
    logic              cache_ready       = 1'b0;
    logic [TAG_W-1:0]  cache_evicted_tag = '0;

    logic              mem_req;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata = '0;
    logic              mem_ack   = 1'b0;

    logic [31:0]       hit_count;
    logic [31:0]       miss_count;

    always #5 clk = ~clk;

    cache_controller #(
        .TAG_W   (TAG_W),
        .INDEX_W (INDEX_W)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .cpu_req           (cpu_req),
        .cpu_we            (cpu_we),
        .cpu_addr          (cpu_addr),
        .cpu_wdata         (cpu_wdata),
        .cpu_rdata         (cpu_rdata),
        .cpu_ready         (cpu_ready),
        .stall             (stall),
        .cache_en          (cache_en),
        .cache_we          (cache_we),
        .cache_from_mem    (cache_from_mem),
        .cache_addr        (cache_addr),
        .cache_wdata       (cache_wdata),
        .cache_rdata       (cache_rdata),
        .cache_hit         (cache_hit),
        .cache_evicted     (cache_evicted),
        .cache_ready       (cache_ready),
        .cache_evicted_tag (cache_evicted_tag),
        .mem_req           (mem_req),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_rdata         (mem_rdata),
        .mem_ack           (mem_ack),
        .hit_count         (hit_count),
        .miss_count        (miss_count)
    );

    // ------------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------------
    int checks = 0;
    int errors = 0;

    int memWait    = 0;
    int cacheStall = 0;

    int rdCnt = 0, wrCnt = 0, enCnt = 0, fillCnt = 0;
    int enViol = 0, memViol = 0, stallViol = 0;
    bit [31:0] lastRdAddr = '0, lastWrAddr = '0, lastWrData = '0;

    bit [31:0] memImg [bit [31:0]];

    typedef struct {
        bit        we;
        bit [31:0] addr;
        bit [31:0] wdata;
        int        mw;
        int        cs;
        bit [31:0] expRdata;
        int        expLat;
        int        expRd;
        int        expWr;
        bit [31:0] expWrAddr;
        bit [31:0] expWrData;
        int        expHits;
        int        expMisses;
    } vec_t;

    function automatic bit [31:0] memInit(input bit [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    function automatic bit [31:0] memRead(input bit [31:0] a);
        if (memImg.exists(a)) return memImg[a];
        return memInit(a);
    endfunction

    // ------------------------------------------------------------------------
    // Behavioural cache array: acts on each enable pulse, then holds
    // cache_ready low for cacheStall further cycles.
    // ------------------------------------------------------------------------
    bit [TAG_W-1:0] cTag   [LINES];
    bit             cValid [LINES];
    bit             cDirty [LINES];
    bit [31:0]      cData  [LINES];
    int             readyCnt = 0;
    bit             prevEn   = 1'b0;

    always @(negedge clk) begin : cacheModel
        int             idx;
        bit [TAG_W-1:0] tag;
        if (cache_en === 1'b1) begin
            enCnt++;
            if (prevEn) enViol++;
            if (cache_from_mem) fillCnt++;
            idx               = int'(cache_addr[12:2]);
            tag               = cache_addr[31:13];
            cache_hit         = cValid[idx] && (cTag[idx] == tag);
            cache_evicted     = 1'b0;
            cache_rdata       = cData[idx];
            cache_evicted_tag = cTag[idx];
            if (cache_we) begin
                cache_evicted = cValid[idx] && cDirty[idx] && (cTag[idx] != tag);
                cTag[idx]     = tag;
                cValid[idx]   = 1'b1;
                cDirty[idx]   = !cache_from_mem;
                cData[idx]    = cache_wdata;
            end
            cache_ready = 1'b0;
            readyCnt    = cacheStall;
        end else if (readyCnt == 0) begin
            cache_ready = 1'b1;
        end else begin
            readyCnt--;
            cache_ready = 1'b0;
        end
        prevEn = (cache_en === 1'b1);
    end

    // ------------------------------------------------------------------------
    // Main memory: acks memWait cycles after a request is first seen and
    // checks that the request stays stable until then.
    // ------------------------------------------------------------------------
    bit        memBusy = 1'b0;
    int        memCnt  = 0;
    bit [31:0] mAddr, mData;
    bit        mWe;

    always @(negedge clk) begin : memModel
        mem_ack = 1'b0;
        if (rst) begin
            memBusy = 1'b0;
        end else begin
            if (memBusy && (!mem_req || mem_addr != mAddr || mem_we != mWe ||
                            (mWe && mem_wdata != mData)))
                memViol++;
            if (mem_req === 1'b1 && !memBusy) begin
                memBusy = 1'b1;
                memCnt  = memWait;
                mAddr   = mem_addr;
                mWe     = mem_we;
                mData   = mem_wdata;
                if (mem_addr[1:0] != 2'b00) memViol++;
            end
            if (memBusy) begin
                if (memCnt == 0) begin
                    mem_ack = 1'b1;
                    memBusy = 1'b0;
                    if (mWe) begin
                        memImg[mAddr] = mData;
                        wrCnt++;
                        lastWrAddr = mAddr;
                        lastWrData = mData;
                    end else begin
                        mem_rdata  = memRead(mAddr);
                        rdCnt++;
                        lastRdAddr = mAddr;
                    end
                end else begin
                    memCnt--;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Comparison helper
    // ------------------------------------------------------------------------
    task automatic checkOutput(input string name, input bit [31:0] act, input bit [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Presents one access, holds cpu_req until cpu_ready, and returns the
    // number of rising edges from acceptance to the cpu_ready cycle.
    task automatic applyStimulus(input bit we, input bit [31:0] addr, input bit [31:0] wdata,
                                 input int mw, input int cs,
                                 output bit [31:0] rdata, output int lat);
        @(negedge clk);
        memWait    = mw;
        cacheStall = cs;
        rdCnt      = 0;
        wrCnt      = 0;
        enCnt      = 0;
        fillCnt    = 0;
        cpu_req    = 1'b1;
        cpu_we     = we;
        cpu_addr   = addr;
        cpu_wdata  = wdata;
        lat        = 0;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
            if (!stall) stallViol++;
            if (cpu_ready) break;
        end
        if (!cpu_ready) lat = -1;
        rdata   = cpu_rdata;
        cpu_req = 1'b0;
        @(posedge clk);
        #1;
        if (cpu_ready || stall) stallViol++;
    endtask

    task automatic checkAccess(input vec_t v, input string name);
        bit [31:0] rdata;
        int        lat;
        applyStimulus(v.we, v.addr, v.wdata, v.mw, v.cs, rdata, lat);
        checkOutput({name, ".rdata"},   rdata,            v.expRdata);
        checkOutput({name, ".latency"}, 32'(lat),         32'(v.expLat));
        checkOutput({name, ".memRd"},   32'(rdCnt),       32'(v.expRd));
        checkOutput({name, ".memWr"},   32'(wrCnt),       32'(v.expWr));
        checkOutput({name, ".cacheEn"}, 32'(enCnt),       32'(1 + v.expRd));
        checkOutput({name, ".fills"},   32'(fillCnt),     32'(v.expRd));
        if (v.expRd > 0)
            checkOutput({name, ".rdAddr"}, lastRdAddr, {v.addr[31:2], 2'b00});
        if (v.expWr > 0) begin
            checkOutput({name, ".wbAddr"}, lastWrAddr, v.expWrAddr);
            checkOutput({name, ".wbData"}, lastWrData, v.expWrData);
        end
        if (v.expHits >= 0) begin
            checkOutput({name, ".hits"},   hit_count,  32'(v.expHits));
            checkOutput({name, ".misses"}, miss_count, 32'(v.expMisses));
        end
    endtask

    // ------------------------------------------------------------------------
    // Random-phase reference: flat memory image plus line residency
    // ------------------------------------------------------------------------
    bit [31:0]      refMem [bit [31:0]];
    bit             refValid [4];
    bit             refDirty [4];
    bit [TAG_W-1:0] refTag   [4];

    function automatic bit [31:0] refRead(input bit [31:0] a);
        if (refMem.exists(a)) return refMem[a];
        return memInit(a);
    endfunction

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    vec_t dirVec [11];

    initial begin : mainSeq
        vec_t v;
        int   seen;
        int   n;
        int   refHits, refMisses;

        memImg[32'h0000_2008] = 32'h1234_5678;
        memImg[32'h0000_2020] = 32'h0BAD_F00D;

        //             we    addr          wdata         mw cs expRdata      lat rd wr wbAddr        wbData        hits miss
        dirVec[0]  = '{1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 0, 0, 32'h0,        3, 0, 0, 32'h0,        32'h0,        0, 0};
        dirVec[1]  = '{1'b0, 32'h0000_1004, 32'h0,         0, 0, 32'hDEAD_BEEF, 3, 0, 0, 32'h0,        32'h0,        1, 0};
        dirVec[2]  = '{1'b0, 32'h0000_2008, 32'h0,         4, 0, 32'h1234_5678, 10, 1, 0, 32'h0,       32'h0,        1, 1};
        dirVec[3]  = '{1'b0, 32'h0000_2008, 32'h0,         0, 0, 32'h1234_5678, 3, 0, 0, 32'h0,        32'h0,        2, 1};
        dirVec[4]  = '{1'b1, 32'h0000_0010, 32'hAAAA_5555, 0, 0, 32'h0,        3, 0, 0, 32'h0,        32'h0,        2, 1};
        dirVec[5]  = '{1'b1, 32'h0000_2010, 32'h0000_0001, 1, 0, 32'h0,        5, 0, 1, 32'h0000_0010, 32'hAAAA_5555, 2, 1};
        dirVec[6]  = '{1'b1, 32'h0000_0020, 32'hCAFE_F00D, 0, 0, 32'h0,        3, 0, 0, 32'h0,        32'h0,        2, 1};
        dirVec[7]  = '{1'b0, 32'h0000_2020, 32'h0,         2, 0, 32'h0BAD_F00D, 11, 1, 1, 32'h0000_0020, 32'hCAFE_F00D, 2, 2};
        dirVec[8]  = '{1'b0, 32'h0000_3030, 32'h0,         0, 2, memInit(32'h0000_3030), 10, 1, 0, 32'h0, 32'h0,   2, 3};
        dirVec[9]  = '{1'b0, 32'h0000_3030, 32'h0,         0, 2, memInit(32'h0000_3030), 5, 0, 0, 32'h0,  32'h0,   3, 3};
        dirVec[10] = '{1'b0, 32'h0000_0010, 32'h0,         0, 0, 32'hAAAA_5555, 7, 1, 1, 32'h0000_2010, 32'h0000_0001, 3, 4};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset.cpu_ready",  32'(cpu_ready), 32'h0);
        checkOutput("reset.stall",      32'(stall),     32'h0);
        checkOutput("reset.cache_en",   32'(cache_en),  32'h0);
        checkOutput("reset.mem_req",    32'(mem_req),   32'h0);
        checkOutput("reset.ctrl",       {29'h0, cache_we, cache_from_mem, mem_we}, 32'h0);
        checkOutput("reset.cpu_rdata",  cpu_rdata,   32'h0);
        checkOutput("reset.mem_addr",   mem_addr,    32'h0);
        checkOutput("reset.mem_wdata",  mem_wdata,   32'h0);
        checkOutput("reset.cache_addr", cache_addr,  32'h0);
        checkOutput("reset.cache_wdata", cache_wdata, 32'h0);
        checkOutput("reset.hits",       hit_count,   32'h0);
        checkOutput("reset.misses",     miss_count,  32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 11; i++) begin
            checkAccess(dirVec[i], $sformatf("dir%0d", i));
        end

        // Reset while waiting on a memory read
        @(negedge clk);
        memWait    = 20;
        cacheStall = 0;
        cpu_req    = 1'b1;
        cpu_we     = 1'b0;
        cpu_addr   = 32'h0000_5050;
        n = 0;
        while (n < 30 && mem_req !== 1'b1) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("rst.reachedMemRd", 32'(mem_req), 32'h1);
        @(negedge clk);
        cpu_req = 1'b0;
        rst     = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst.mem_req",   32'(mem_req),   32'h0);
        checkOutput("rst.cache_en",  32'(cache_en),  32'h0);
        checkOutput("rst.stall",     32'(stall),     32'h0);
        checkOutput("rst.cpu_ready", 32'(cpu_ready), 32'h0);
        checkOutput("rst.mem_addr",  mem_addr,       32'h0);
        checkOutput("rst.cache_addr", cache_addr,    32'h0);
        checkOutput("rst.hits",      hit_count,      32'h0);
        checkOutput("rst.misses",    miss_count,     32'h0);
        @(posedge clk);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (cpu_ready || mem_req || cache_en || stall) seen++;
        end
        checkOutput("rst.quietAfter", 32'(seen), 32'h0);

        // Randomized accesses over four lines and three tags
        refHits   = 0;
        refMisses = 0;
        for (int k = 0; k < 4; k++) begin
            refValid[k] = 1'b0;
            refDirty[k] = 1'b0;
            refTag[k]   = '0;
        end
        for (int r = 0; r < 150; r++) begin
            int             k;
            bit [TAG_W-1:0] tag;
            bit [31:0]      a;
            bit             hit, evict;
            k           = $urandom_range(0, 3);
            tag         = TAG_W'(32'h40000 + $urandom_range(0, 2));
            v.we        = 1'($urandom_range(0, 1));
            v.wdata     = $urandom;
            v.mw        = $urandom_range(0, 3);
            v.cs        = $urandom_range(0, 2);
            v.addr      = {tag, INDEX_W'(32'h100 + k), 2'($urandom_range(0, 3))};
            a           = {v.addr[31:2], 2'b00};
            hit         = refValid[k] && refTag[k] == tag;
            evict       = refValid[k] && refDirty[k] && refTag[k] != tag;
            v.expWr     = evict ? 1 : 0;
            v.expWrAddr = {refTag[k], INDEX_W'(32'h100 + k), 2'b00};
            v.expWrData = refRead(v.expWrAddr);
            v.expHits   = -1;
            v.expMisses = -1;
            if (v.we) begin
                v.expRdata  = '0;
                v.expRd     = 0;
                v.expLat    = evict ? 4 + v.cs + v.mw : 3 + v.cs;
                refMem[a]   = v.wdata;
                refDirty[k] = 1'b1;
            end else begin
                v.expRdata = refRead(a);
                if (hit) begin
                    refHits++;
                    v.expRd  = 0;
                    v.expWr  = 0;
                    v.expLat = 3 + v.cs;
                end else begin
                    refMisses++;
                    v.expRd     = 1;
                    v.expLat    = 6 + 2 * v.cs + v.mw + (evict ? 1 + v.mw : 0);
                    refDirty[k] = 1'b0;
                end
            end
            refValid[k] = 1'b1;
            refTag[k]   = tag;
            checkAccess(v, $sformatf("rnd%0d", r));
        end
        checkOutput("rnd.hits",   hit_count,  32'(refHits));
        checkOutput("rnd.misses", miss_count, 32'(refMisses));

        // Protocol monitors
        checkOutput("mon.cacheEnBackToBack", 32'(enViol),    32'h0);
        checkOutput("mon.memHandshake",      32'(memViol),   32'h0);
        checkOutput("mon.stallReady",        32'(stallViol), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
